pe_tile_param: RTL and testbench

//  Parametrised next-generation PE tile for the CGRA array: WIDTH-bit datapath, NUM_TRACKS tracks per side, 4 sides.

---
 rtl/pe_tile_param.sv | 193 +++++++++++++++++++
 tb/tb_pe_tile_param.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pe_tile_param.sv
// pe_tile_param: CGRA PE tile with two connect boxes, a 4-side switch box and a registered
// multi-op PE with accumulator, configured over a tile-addressed config bus.
// Optional build macro PE_TILE_SB_REG_EN registers every out_wire lane (SB latency 1 cycle).
module pe_tile_param #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned NUM_TRACKS = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [15:0]                      tile_id,
    input  logic [31:0]                      config_addr,
    input  logic [31:0]                      config_data,
    input  logic                             config_write,
    input  logic                             config_read,
    output logic [31:0]                      read_data,
    output logic                             read_valid,
    input  logic [4*NUM_TRACKS*WIDTH-1:0]    in_wire,
    output logic [4*NUM_TRACKS*WIDTH-1:0]    out_wire
);

    localparam int unsigned CBW = $clog2(2 * NUM_TRACKS);
    localparam int unsigned SBW = 2 * NUM_TRACKS;
    localparam int unsigned BUSW = 4 * NUM_TRACKS * WIDTH;

    typedef enum logic [2:0] {
        OpAdd, OpSub, OpAnd, OpOr, OpXor, OpMul, OpAcc, OpPass
    } op_e;

    op_e                  opcode_q;
    logic [CBW-1:0]       cb0_sel_q, cb1_sel_q;
    logic [3:0][SBW-1:0]  sb_sel_q;
    logic [WIDTH-1:0]     acc_q, acc_sum, pe_res, pe_out_q;
    logic [WIDTH-1:0]     op_a, op_b;
    logic [BUSW-1:0]      sb_out;
    logic [31:0]          rd_mux, read_data_q;
    logic                 read_valid_q;
    logic                 match, wr_en, rd_en;
    logic                 wr_pe, wr_cb0, wr_cb1;
    logic [3:0]           wr_sb;
    logic [7:0]           feat, idx;
    logic                 unused_cfg;

    assign feat  = config_addr[31:24];
    assign idx   = config_addr[23:16];
    assign match = (config_addr[15:0] == tile_id);
    assign wr_en = config_write && match;
    assign rd_en = config_read && match;

    // Only the low bits of config_data are meaningful for any register.
    assign unused_cfg = ^config_data;

    // Address decode: write enables and zero-extended readback mux (0 for unknown regs).
    always_comb begin
        wr_pe  = 1'b0;
        wr_cb0 = 1'b0;
        wr_cb1 = 1'b0;
        wr_sb  = 4'b0;
        rd_mux = 32'd0;
        case (feat)
            8'd4: if (idx == 8'd0) begin
                wr_pe  = wr_en;
                rd_mux = 32'(opcode_q);
            end
            8'd5: if (idx == 8'd0) begin
                wr_cb1 = wr_en;
                rd_mux = 32'(cb1_sel_q);
            end
            8'd6: if (idx == 8'd0) begin
                wr_cb0 = wr_en;
                rd_mux = 32'(cb0_sel_q);
            end
            8'd7: if (idx < 8'd4) begin
                wr_sb[idx[1:0]] = wr_en;
                rd_mux          = 32'(sb_sel_q[idx[1:0]]);
            end
            default: ;
        endcase
    end

    // Config register file; reset wins over a same-cycle write.
    always_ff @(posedge clk) begin
        if (reset) begin
            opcode_q  <= OpAdd;
            cb0_sel_q <= '0;
            cb1_sel_q <= '0;
            sb_sel_q  <= '0;
        end else begin
            if (wr_pe)  opcode_q  <= op_e'(config_data[2:0]);
            if (wr_cb0) cb0_sel_q <= config_data[CBW-1:0];
            if (wr_cb1) cb1_sel_q <= config_data[CBW-1:0];
            for (int s = 0; s < 4; s++) begin
                if (wr_sb[s]) sb_sel_q[s] <= config_data[SBW-1:0];
            end
        end
    end

    // Readback register: samples the pre-write value, so a same-cycle write reads old data.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_valid_q <= 1'b0;
            read_data_q  <= 32'd0;
        end else begin
            read_valid_q <= rd_en;
            if (rd_en) read_data_q <= rd_mux;
        end
    end

    assign read_valid = read_valid_q;
    assign read_data  = read_data_q;

    // Connect-box lane pick: in_wire track, then out_wire track of the same side.
    function automatic logic [WIDTH-1:0] cb_pick(input logic [CBW-1:0] sel,
                                                 input int unsigned side,
                                                 input logic [BUSW-1:0] inw,
                                                 input logic [BUSW-1:0] outw);
        int unsigned s;
        s       = 32'(sel);
        cb_pick = '0;
        if (s < NUM_TRACKS) begin
            cb_pick = inw[(side * NUM_TRACKS + s) * WIDTH +: WIDTH];
        end else if (s < 2 * NUM_TRACKS) begin
            cb_pick = outw[(side * NUM_TRACKS + s - NUM_TRACKS) * WIDTH +: WIDTH];
        end
    endfunction

    // Operand selection: CB0 on side 0 feeds op_a, CB1 on side 1 feeds op_b.
    always_comb begin
        op_a = cb_pick(cb0_sel_q, 0, in_wire, out_wire);
        op_b = cb_pick(cb1_sel_q, 1, in_wire, out_wire);
    end

    // Switch box: each output lane takes a track from another side or the PE result.
    always_comb begin
        sb_out = '0;
        for (int s = 0; s < 4; s++) begin
            for (int t = 0; t < NUM_TRACKS; t++) begin
                case (sb_sel_q[s][2*t +: 2])
                    2'd0: sb_out[(s*NUM_TRACKS+t)*WIDTH +: WIDTH] =
                              in_wire[(((s+1)%4)*NUM_TRACKS+t)*WIDTH +: WIDTH];
                    2'd1: sb_out[(s*NUM_TRACKS+t)*WIDTH +: WIDTH] =
                              in_wire[(((s+2)%4)*NUM_TRACKS+t)*WIDTH +: WIDTH];
                    2'd2: sb_out[(s*NUM_TRACKS+t)*WIDTH +: WIDTH] =
                              in_wire[(((s+3)%4)*NUM_TRACKS+t)*WIDTH +: WIDTH];
                    default: sb_out[(s*NUM_TRACKS+t)*WIDTH +: WIDTH] = pe_out_q;
                endcase
            end
        end
    end

`ifdef PE_TILE_SB_REG_EN
    logic [BUSW-1:0] out_q;

    // Registered switch-box outputs.
    always_ff @(posedge clk) begin
        if (reset) out_q <= '0;
        else       out_q <= sb_out;
    end

    assign out_wire = out_q;
`else
    assign out_wire = sb_out;
`endif

    // PE result mux; arithmetic wraps modulo 2^WIDTH.
    always_comb begin
        acc_sum = acc_q + op_a;
        pe_res  = '0;
        unique case (opcode_q)
            OpAdd:  pe_res = op_a + op_b;
            OpSub:  pe_res = op_a - op_b;
            OpAnd:  pe_res = op_a & op_b;
            OpOr:   pe_res = op_a | op_b;
            OpXor:  pe_res = op_a ^ op_b;
            OpMul:  pe_res = op_a * op_b;
            OpAcc:  pe_res = acc_sum;
            OpPass: pe_res = op_a;
            default: pe_res = '0;
        endcase
    end

    // PE output register and accumulator; any PE config write clears the accumulator.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            pe_out_q <= '0;
        end else begin
            pe_out_q <= pe_res;
            if (wr_pe)                acc_q <= '0;
            else if (opcode_q == OpAcc) acc_q <= acc_sum;
        end
    end

endmodule

// File: tb/tb_pe_tile_param.sv
// Directed bench for pe_tile_param (WIDTH=16, NUM_TRACKS=4, tile_id=3) with a readback scoreboard.
module tb_pe_tile_param;

    localparam int W  = 16;
    localparam int NT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [15:0]       tile_id;
    logic [31:0]       config_addr, config_data, read_data;
    logic              config_write, config_read, read_valid;
    logic [4*NT*W-1:0] in_wire, out_wire;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    pe_tile_param #(.WIDTH(W), .NUM_TRACKS(NT)) dut (
        .clk          (clk),
        .reset        (reset),
        .tile_id      (tile_id),
        .config_addr  (config_addr),
        .config_data  (config_data),
        .config_write (config_write),
        .config_read  (config_read),
        .read_data    (read_data),
        .read_valid   (read_valid),
        .in_wire      (in_wire),
        .out_wire     (out_wire)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Extra cycle for the registered switch-box build.
    task automatic sb_lat();
`ifdef PE_TILE_SB_REG_EN
        tick();
`endif
    endtask

    function automatic logic [31:0] lane(input int s, input int t);
        return 32'(out_wire[(s*NT+t)*W +: W]);
    endfunction

    task automatic set_in(input int s, input int t, input logic [15:0] v);
        in_wire[(s*NT+t)*W +: W] = v;
    endtask

    task automatic cfg_write(input logic [7:0] f, input logic [7:0] i, input logic [15:0] tid,
                             input logic [31:0] d);
        config_addr  = {f, i, tid};
        config_data  = d;
        config_write = 1'b1;
        tick();
        config_write = 1'b0;
    endtask

    task automatic cfg_read(input logic [7:0] f, input logic [7:0] i, input logic [31:0] e,
                            input string tag);
        logic [31:0] exp_v;
        config_addr = {f, i, 16'h0003};
        config_read = 1'b1;
        exp_q.push_back(e);
        tick();
        config_read = 1'b0;
        check({tag, "_valid"}, 32'(read_valid), 32'd1);
        exp_v = exp_q.pop_front();
        check(tag, read_data, exp_v);
    endtask

    task automatic pe_op(input logic [2:0] op, input logic [15:0] e, input string tag);
        cfg_write(8'd4, 8'd0, 16'h0003, 32'(op));
        tick();
        sb_lat();
        check(tag, lane(0, 3), 32'(e));
    endtask

    initial begin
        logic [31:0] exp_v;
        tile_id      = 16'h0003;
        reset        = 1'b1;
        config_addr  = 32'd0;
        config_data  = 32'd0;
        config_write = 1'b0;
        config_read  = 1'b0;
        in_wire      = '0;
        tick();
        tick();
        reset = 1'b0;

        // 1. Reset state
        check("rst_valid", 32'(read_valid), 32'd0);
        check("rst_rdata", read_data, 32'd0);
        for (int s = 0; s < 4; s++)
            for (int t = 0; t < NT; t++)
                check("rst_out", lane(s, t), 32'd0);
        cfg_read(8'd7, 8'd0, 32'd0, "rst_sb0");

        // 2. Switch box routing
        cfg_write(8'd7, 8'd0, 16'h0003, 32'h0000_00E4);
        set_in(1, 0, 16'h1111);
        set_in(2, 1, 16'h2222);
        set_in(3, 2, 16'h3333);
        tick();
        sb_lat();
        check("sb_s0t0", lane(0, 0), 32'h1111);
        check("sb_s0t1", lane(0, 1), 32'h2222);
        check("sb_s0t2", lane(0, 2), 32'h3333);
        check("sb_s0t3_pe", lane(0, 3), 32'h1111);
        check("sb_s1t1", lane(1, 1), 32'h2222);
        cfg_read(8'd7, 8'd0, 32'h0000_00E4, "rd_sb0");

        // 3. PE ops through the connect boxes
        set_in(0, 2, 16'h0005);
        set_in(1, 3, 16'h0007);
        cfg_write(8'd6, 8'd0, 16'h0003, 32'd2);
        cfg_write(8'd5, 8'd0, 16'h0003, 32'd3);
        pe_op(3'd1, 16'hFFFE, "pe_sub");
        cfg_write(8'd5, 8'd0, 16'h0003, 32'd5);   // op_b from out_wire side1 t1 = 2222
        pe_op(3'd5, 16'hAAAA, "pe_mul");
        set_in(0, 2, 16'h0F0F);
        pe_op(3'd2, 16'h0202, "pe_and");
        pe_op(3'd3, 16'h2F2F, "pe_or");
        pe_op(3'd4, 16'h2D2D, "pe_xor");
        set_in(0, 2, 16'hFFFF);
        pe_op(3'd0, 16'h2221, "pe_add_wrap");
        pe_op(3'd7, 16'hFFFF, "pe_pass");

        // 4. Accumulator wrap and clear on PE write
        set_in(0, 2, 16'h8000);
        pe_op(3'd6, 16'h8000, "acc_1");
        tick();
        check("acc_2", lane(0, 3), 32'h0000);
        tick();
        check("acc_3", lane(0, 3), 32'h8000);
        set_in(0, 2, 16'h0001);
        pe_op(3'd6, 16'h0001, "acc_clear");
        cfg_read(8'd4, 8'd0, 32'd6, "rd_op");

        // 5. Same-cycle write/read, foreign tile, unknown regs, dropped bits
        config_addr  = 32'h0600_0003;
        config_data  = 32'd5;
        config_write = 1'b1;
        config_read  = 1'b1;
        exp_q.push_back(32'd2);
        tick();
        config_write = 1'b0;
        config_read  = 1'b0;
        check("wr_rd_valid", 32'(read_valid), 32'd1);
        exp_v = exp_q.pop_front();
        check("wr_rd_old", read_data, exp_v);
        cfg_read(8'd6, 8'd0, 32'd5, "rd_cb0_new");
        cfg_write(8'd6, 8'd0, 16'h0004, 32'd1);
        config_addr = 32'h0600_0004;
        config_read = 1'b1;
        tick();
        config_read = 1'b0;
        check("foreign_valid", 32'(read_valid), 32'd0);
        cfg_read(8'd6, 8'd0, 32'd5, "foreign_nochg");
        cfg_read(8'd8, 8'd0, 32'd0, "rd_bad_feat");
        cfg_read(8'd4, 8'd1, 32'd0, "rd_bad_idx");
        cfg_write(8'd7, 8'd4, 16'h0003, 32'h0000_00FF);
        cfg_read(8'd7, 8'd0, 32'h0000_00E4, "sb_idx4_ign");
        cfg_write(8'd5, 8'd0, 16'h0003, 32'hFFFF_FFF9);
        cfg_read(8'd5, 8'd0, 32'd1, "cb1_trunc");
        cfg_write(8'd7, 8'd3, 16'h0003, 32'h0000_0055);
        cfg_read(8'd7, 8'd3, 32'h0000_0055, "rd_sb3");

        // 6. Reset cancels pending read and beats a same-cycle write
        in_wire      = '0;
        config_addr  = 32'h0600_0003;
        config_data  = 32'd7;
        config_write = 1'b1;
        config_read  = 1'b1;
        reset        = 1'b1;
        tick();
        config_write = 1'b0;
        config_read  = 1'b0;
        check("rst_cancel_valid", 32'(read_valid), 32'd0);
        check("rst_cancel_data", read_data, 32'd0);
        reset = 1'b0;
        for (int s = 0; s < 4; s++)
            for (int t = 0; t < NT; t++)
                check("rst2_out", lane(s, t), 32'd0);
        cfg_read(8'd6, 8'd0, 32'd0, "rst2_cb0");
        cfg_read(8'd5, 8'd0, 32'd0, "rst2_cb1");
        cfg_read(8'd4, 8'd0, 32'd0, "rst2_op");
        cfg_read(8'd7, 8'd0, 32'd0, "rst2_sb0");
        cfg_read(8'd7, 8'd3, 32'd0, "rst2_sb3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
